// File: rtl/net_pattern_drvr.sv
// net_pattern_drvr: programmable const/toggle/LFSR source for a high-fanout net, stepping every hold+1 cycles
`timescale 1ns/1ps
module net_pattern_drvr #(
  parameter logic [7:0] SEED = 8'hA5,
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_mode,
  input  logic [HOLD_W-1:0] cfg_hold,
  input  logic              run,
  output logic              net_out,
  output logic              step,
  output logic              busy,
  output logic [15:0]       step_count
);
  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;
  localparam logic [7:0] SEED_V = (SEED == 8'h00) ? 8'h01 : SEED;
  state_t state, state_nx;
  logic [1:0] mode;
  logic [HOLD_W-1:0] hold, cnt;
  logic [7:0] lfsr, lfsr_nx;
  logic accept, upd;
  assign cfg_ready = state != RUN;
  assign accept = cfg_valid & cfg_ready;
  assign upd = (state == RUN) && run && (cnt == '0);
  assign lfsr_nx = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  // a cfg offer always beats run, so ARMED+accept+run stays ARMED
  always_comb begin
    state_nx = state;
    state_nx = accept ? ARMED :
               (state == ARMED && run) ? RUN :
               (state == RUN && !run) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode       <= 2'b00;
      hold       <= '0;
      cnt        <= '0;
      lfsr       <= SEED_V;
      net_out    <= 1'b0;
      step       <= 1'b0;
      busy       <= 1'b0;
      step_count <= 16'd0;
    end else begin
      state <= state_nx;
      busy  <= state_nx == RUN;
      step  <= upd;
      if (accept) begin
        mode       <= cfg_mode;
        hold       <= cfg_hold;
        step_count <= 16'd0;
        if (cfg_mode == 2'b11) lfsr <= SEED_V;
      end
      if (state == ARMED && state_nx == RUN) cnt <= hold;
      else if (state == RUN && run) cnt <= (cnt == '0) ? hold : cnt - 1'b1;
      if (upd) begin
        step_count <= step_count + 16'd1;
        net_out    <= mode[1] ? (mode[0] ? lfsr_nx[0] : ~net_out) : mode[0];
        if (mode == 2'b11) lfsr <= lfsr_nx;
      end
    end
  end
endmodule

// File: tb/tb_net_pattern_drvr.sv
// tb_net_pattern_drvr: directed scenarios plus random traffic against a phase/edge-count reference model
`timescale 1ns/1ps
module tb_net_pattern_drvr;
  logic clk = 0, rst_n = 0, cfg_valid = 0, run = 0;
  logic [1:0] cfg_mode = 0;
  logic [3:0] cfg_hold = 0;
  logic cfg_ready, net_out, step, busy;
  logic [15:0] step_count;
  int tests = 0, fails = 0;
  // model: ph 0=idle 1=armed 2=run; k = edges spent in RUN since entry
  int ph, m_hold, k;
  logic [1:0] m_mode;
  logic [7:0] m_lfsr;
  logic m_net, m_step;
  logic [15:0] m_cnt;

  net_pattern_drvr dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mode(cfg_mode), .cfg_hold(cfg_hold), .run(run), .net_out(net_out),
    .step(step), .busy(busy), .step_count(step_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & 8'hB8)};
  endfunction

  function automatic logic [19:0] model_out();
    return {m_net, m_step, ph == 2, ph != 2, m_cnt};
  endfunction

  function automatic logic [19:0] dut_out();
    return {net_out, step, busy, cfg_ready, step_count};
  endfunction

  task automatic model_reset();
    ph = 0; m_mode = 0; m_hold = 0; m_lfsr = 8'hA5; m_net = 0; m_step = 0; m_cnt = 0; k = 0;
  endtask

  task automatic cycle(input logic v, input logic [1:0] md, input logic [3:0] h, input logic r);
    cfg_valid = v; cfg_mode = md; cfg_hold = h; run = r;
    @(posedge clk);
    m_step = 0;
    if (v && ph != 2) begin
      m_mode = md; m_hold = int'(h); m_cnt = 0; ph = 1;
      if (md == 2'b11) m_lfsr = 8'hA5;
    end else if (ph == 1 && r) begin
      ph = 2; k = 0;
    end else if (ph == 2 && !r) begin
      ph = 0;
    end else if (ph == 2) begin
      k++;
      if (k % (m_hold + 1) == 0) begin
        m_step = 1; m_cnt++;
        case (m_mode)
          2'b00: m_net = 0;
          2'b01: m_net = 1;
          2'b10: m_net = ~m_net;
          default: begin m_lfsr = lfsr_next(m_lfsr); m_net = m_lfsr[0]; end
        endcase
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    tests++;
    if (dut_out() !== 20'h10000) begin fails++; $display("FAIL reset_init act=%h exp=%h", dut_out(), 20'h10000); end
    @(negedge clk); rst_n = 1;
    cycle(1, 2'b10, 4'd0, 0);
    cycle(0, 2'b00, 4'd0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 2'b00, 4'd0, 1);
    rst_n = 0; #1;
    model_reset();
    tests++;
    if (dut_out() !== 20'h10000) begin fails++; $display("FAIL reset_midrun act=%h exp=%h", dut_out(), 20'h10000); end
    @(negedge clk); rst_n = 1;
    cycle(0, 2'b00, 4'd0, 1);
    tests++;
    if (dut_out() !== model_out() || busy !== 0) begin fails++; $display("FAIL reset_idle act=%h exp=%h", dut_out(), model_out()); end
  endtask

  task automatic test_toggle();
    cycle(1, 2'b10, 4'd0, 0);
    cycle(0, 2'b00, 4'd0, 1);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 2'b00, 4'd0, 1);
      tests++;
      if (dut_out() !== model_out() || net_out !== (i % 2 == 0) || step !== 1)
        begin fails++; $display("FAIL toggle_%0d act=%h exp=%h", i, dut_out(), model_out()); end
    end
    tests++;
    if (step_count !== 16'd6) begin fails++; $display("FAIL toggle_count act=%0d exp=6", step_count); end
    cycle(0, 2'b00, 4'd0, 0);
  endtask

  task automatic test_lfsr();
    logic en [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    cycle(1, 2'b11, 4'd2, 0);
    cycle(0, 2'b00, 4'd0, 1);
    for (int e = 1; e <= 12; e++) begin
      cycle(0, 2'b00, 4'd0, 1);
      tests++;
      if (dut_out() !== model_out() || step !== (e % 3 == 0) || (e % 3 == 0 && net_out !== en[e/3-1]))
        begin fails++; $display("FAIL lfsr_e%0d act=%h exp=%h", e, dut_out(), model_out()); end
    end
    cycle(0, 2'b00, 4'd0, 0);
  endtask

  task automatic test_collision();
    cycle(1, 2'b10, 4'd1, 0);
    cycle(1, 2'b01, 4'd3, 1);
    tests++;
    if (dut_out() !== model_out() || busy !== 0 || cfg_ready !== 1 || step_count !== 0)
      begin fails++; $display("FAIL collide_armed act=%h exp=%h", dut_out(), model_out()); end
    cycle(0, 2'b00, 4'd0, 1);
    tests++;
    if (busy !== 1 || cfg_ready !== 0) begin fails++; $display("FAIL collide_run busy=%b ready=%b exp 1 0", busy, cfg_ready); end
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 2'b00, 4'd0, 1);
      tests++;
      if (dut_out() !== model_out() || net_out !== (i == 4))
        begin fails++; $display("FAIL collide_e%0d act=%h exp=%h", i, dut_out(), model_out()); end
    end
    cycle(0, 2'b00, 4'd0, 0);
  endtask

  task automatic test_stop_boundary();
    logic saved;
    cycle(1, 2'b10, 4'd1, 0);
    cycle(0, 2'b00, 4'd0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 2'b00, 4'd0, 1);
    saved = net_out;
    cycle(0, 2'b00, 4'd0, 0);
    tests++;
    if (dut_out() !== model_out() || step !== 0 || busy !== 0 || cfg_ready !== 1 || net_out !== saved)
      begin fails++; $display("FAIL stop_boundary act=%h exp=%h", dut_out(), model_out()); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom % 5 == 0, 2'($urandom), 4'($urandom % 4), $urandom % 8 != 0);
      tests++;
      if (dut_out() !== model_out()) begin fails++; $display("FAIL random_%0d act=%h exp=%h", i, dut_out(), model_out()); end
    end
    cycle(0, 2'b00, 4'd0, 0);
  endtask

  task automatic test_wrap();
    logic [15:0] e = 16'hFFFE;
    cycle(1, 2'b01, 4'd0, 0);
    cycle(0, 2'b00, 4'd0, 1);
    repeat (65534) cycle(0, 2'b00, 4'd0, 1);
    tests++;
    if (dut_out() !== model_out() || step_count !== e) begin fails++; $display("FAIL wrap_pre act=%h exp=%h", dut_out(), model_out()); end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 2'b00, 4'd0, 1);
      e = e + 16'd1;
      tests++;
      if (dut_out() !== model_out() || step_count !== e || net_out !== 1)
        begin fails++; $display("FAIL wrap_%0d act=%h exp=%h", i, step_count, e); end
    end
    cycle(0, 2'b00, 4'd0, 0);
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_lfsr();
    test_collision();
    test_stop_boundary();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/net_pattern_drvr.md
# net_pattern_drvr

Sequential driver for the shared high-fanout net that feeds the resizer's buffered load tree: top-level loads, the hierarchical module loads and the primary output. It replaces a constant tie-off driver with a configurable source: constant 0, constant 1, toggle or 8-bit LFSR. The output updates at a programmable step period. The net then has real switching activity for buffering, timing and power checks.

## Interface
- SEED, 8'hA5, LFSR reload value; 0 is illegal and is replaced by 8'h01.
- HOLD_W, 4, width of the step-period field.
- Clock/reset (already decided): one clock; reset asynchronous, active-low.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  configuration offer.
- cfg_ready  out  1  configuration acceptance window; combinational from state.
- cfg_mode  in  2  00 const0, 01 const1, 10 toggle, 11 LFSR.
- cfg_hold  in  HOLD_W  step period minus one.
- run  in  1  level request to generate.
- net_out  out  1  registered driver of the fanout net.
- step  out  1  one-cycle pulse, high in each cycle following a net_out update edge.
- busy  out  1  high while in RUN.
- step_count  out  16  count of step pulses; wraps.

## Operation
- States: IDLE, ARMED, RUN. Reset state is IDLE.
- Reset values: net_out=0, step=0, busy=0, step_count=0, cfg_ready=1, mode=00, hold=0, lfsr=SEED.
- cfg_ready=1 in IDLE and ARMED; 0 in RUN.
- Accept = cfg_valid & cfg_ready. On accept:
  - latch mode and hold;
  - clear step_count;
  - if mode=11, reload lfsr=SEED;
  - next state is ARMED.
- ARMED with no accept and run=1: go to RUN and load cnt=hold.
- ARMED with accept and run=1 in the same cycle: the cfg wins and the state stays ARMED. run is sampled again next cycle.
- RUN, each edge with run=1:
  - if cnt≠0: cnt←cnt−1;
  - if cnt=0: update net_out per mode, step←1, step_count←step_count+1, cnt←hold.
- Mode actions on update:
  - const0: net_out←0.
  - const1: net_out←1.
  - toggle: net_out←~net_out.
  - LFSR: lfsr←{lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]} and net_out←new lfsr[0].
- RUN with run=0: go to IDLE at the next edge.
  - No update and no step occur at that edge, even if cnt=0.
  - net_out keeps its last value. lfsr and step_count are retained.
- IDLE with run=1 and no accept: stay IDLE. A cfg must be accepted first.
- A new cfg in ARMED does not change net_out. The next RUN resumes from the current net_out and lfsr state, unless the lfsr was reseeded by a mode=11 accept.
- step_count wraps from 16'hFFFF to 0 with no flag.

## Timing
- Let E0 be the edge at which the state becomes RUN. The first net_out update is at edge E0+hold+1. Subsequent updates follow every hold+1 edges.
- step is registered alongside net_out. It is high exactly in the cycle after each update edge.
- hold=0 gives an update every cycle while in RUN, and step stays high continuously.
- busy is registered from the state: it rises at E0 and falls at the edge that leaves RUN.
- cfg_ready falls in the cycle the state becomes RUN. It is combinational, so there is no extra latency.
- rst_n low at any time, including mid-RUN or mid-step:
  - all outputs take their reset values immediately;
  - cfg_ready=1 while rst_n is low.
- rst_n deassertion is synchronised externally and requires no extra cycle.

## Test plan
- Reset: assert rst_n=0 mid-RUN with toggle mode. Required: net_out=0, step=0, busy=0, step_count=0 and cfg_ready=1 immediately; state IDLE after release.
- Toggle, hold=0: accept mode=10, then run=1 for 6 cycles. Required: net_out sequence 1,0,1,0,1,0; step high throughout; step_count=6.
- LFSR, hold=2, SEED=8'hA5: accept mode=11, then run=1. Required:
  - lfsr sequence 8'h4A, 8'h95, 8'h2A, 8'h54;
  - net_out sequence 0,1,0,0;
  - updates at E0+3, E0+6, E0+9, E0+12.
- Handshake collision: in ARMED, drive cfg_valid=1 (mode=01) together with run=1. Required: cfg accepted, state stays ARMED, busy=0. With run held, RUN is entered one cycle later and net_out=1 after hold+1 edges.
- Stop at boundary: hold=1, toggle mode; drop run in a cycle where cnt=0. Required: no update, no step, IDLE next cycle, net_out unchanged, cfg_ready=1.
- Counter wrap: preload step_count to 16'hFFFE with const1 mode and hold=0, then run 3 cycles. Required: step_count goes FFFF, 0000, 0001, and net_out holds 1.
